// File: rtl/joy_poll_sched.sv
// Two-player joystick poll scheduler sharing one SPI reader; one transaction per player per round.
// Optional JOY_FILTER_EN: each successful latch stores the average of the old and new sample.
module joy_poll_sched #(
    parameter int POLL_DIV = 2500000,
    parameter int TIMEOUT  = 4096,
    parameter int CENTER   = 512
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       en,
    output logic       spi_req,
    output logic       spi_sel,
    input  logic       spi_done,
    input  logic [9:0] spi_x,
    input  logic [9:0] spi_y,
    output logic [9:0] joy1_x,
    output logic [9:0] joy1_y,
    output logic [9:0] joy2_x,
    output logic [9:0] joy2_y,
    output logic       upd1,
    output logic       upd2,
    output logic [1:0] err,
    output logic       overrun,
    output logic [2:0] dbg_state
);

    localparam int TCW = $clog2(POLL_DIV);
    localparam int WCW = $clog2(TIMEOUT);
    localparam logic [9:0] CTR = 10'(CENTER);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ1  = 3'd1,
        S_WAIT1 = 3'd2,
        S_REQ2  = 3'd3,
        S_WAIT2 = 3'd4
    } state_t;

    state_t           r_state;
    logic [TCW-1:0]   r_tick_cnt;
    logic [WCW-1:0]   r_wait_cnt;
    logic             r_spi_req, r_spi_sel, r_upd1, r_upd2, r_overrun;
    logic [1:0]       r_err;
    logic [9:0]       r_joy1_x, r_joy1_y, r_joy2_x, r_joy2_y;

    logic             w_tick, w_timeout;
    logic [9:0]       w_nx1, w_ny1, w_nx2, w_ny2;

    assign w_tick    = (r_tick_cnt == '0);
    assign w_timeout = (r_wait_cnt == WCW'(TIMEOUT - 1)) && !spi_done;

`ifdef JOY_FILTER_EN
    assign w_nx1 = 10'((11'(r_joy1_x) + 11'(spi_x)) >> 1);
    assign w_ny1 = 10'((11'(r_joy1_y) + 11'(spi_y)) >> 1);
    assign w_nx2 = 10'((11'(r_joy2_x) + 11'(spi_x)) >> 1);
    assign w_ny2 = 10'((11'(r_joy2_y) + 11'(spi_y)) >> 1);
`else
    assign w_nx1 = spi_x;
    assign w_ny1 = spi_y;
    assign w_nx2 = spi_x;
    assign w_ny2 = spi_y;
`endif

    // Free-running round timer, independent of FSM state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)      r_tick_cnt <= TCW'(POLL_DIV - 1);
        else if (w_tick) r_tick_cnt <= TCW'(POLL_DIV - 1);
        else             r_tick_cnt <= r_tick_cnt - TCW'(1);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_spi_req  <= 1'b0;
            r_spi_sel  <= 1'b0;
            r_upd1     <= 1'b0;
            r_upd2     <= 1'b0;
            r_err      <= 2'b00;
            r_overrun  <= 1'b0;
            r_joy1_x   <= CTR;
            r_joy1_y   <= CTR;
            r_joy2_x   <= CTR;
            r_joy2_y   <= CTR;
        end else begin
            r_spi_req <= 1'b0;
            r_upd1    <= 1'b0;
            r_upd2    <= 1'b0;
            if (w_tick && r_state != S_IDLE) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_spi_sel <= 1'b0;
                    if (w_tick && en) begin
                        r_state   <= S_REQ1;
                        r_spi_req <= 1'b1;
                    end
                end
                S_REQ1: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT1;
                end
                S_WAIT1: begin
                    // Completion outranks a timeout landing in the same cycle.
                    if (spi_done || w_timeout) begin
                        r_joy1_x  <= spi_done ? w_nx1 : CTR;
                        r_joy1_y  <= spi_done ? w_ny1 : CTR;
                        r_upd1    <= spi_done;
                        if (!spi_done) r_err[0] <= 1'b1;
                        r_state   <= S_REQ2;
                        r_spi_req <= 1'b1;
                        r_spi_sel <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCW'(1);
                    end
                end
                S_REQ2: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT2;
                end
                S_WAIT2: begin
                    if (spi_done || w_timeout) begin
                        r_joy2_x  <= spi_done ? w_nx2 : CTR;
                        r_joy2_y  <= spi_done ? w_ny2 : CTR;
                        r_upd2    <= spi_done;
                        if (!spi_done) r_err[1] <= 1'b1;
                        r_state   <= S_IDLE;
                        r_spi_sel <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign spi_req   = r_spi_req;
    assign spi_sel   = r_spi_sel;
    assign upd1      = r_upd1;
    assign upd2      = r_upd2;
    assign err       = r_err;
    assign overrun   = r_overrun;
    assign joy1_x    = r_joy1_x;
    assign joy1_y    = r_joy1_y;
    assign joy2_x    = r_joy2_x;
    assign joy2_y    = r_joy2_y;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_joy_poll_sched.sv
// Bench for joy_poll_sched: reader model drives done/data, scoreboard checks each latched update.
module tb_joy_poll_sched;

    localparam int POLL_DIV = 16;
    localparam int TIMEOUT  = 8;
    localparam logic [9:0] CENTER = 10'd512;
    localparam int W = 21;

    logic       clk = 1'b0;
    logic       clr_n, en, spi_done;
    logic [9:0] spi_x, spi_y;
    logic       spi_req, spi_sel, upd1, upd2, overrun;
    logic [9:0] joy1_x, joy1_y, joy2_x, joy2_y;
    logic [1:0] err;
    logic [2:0] dbg_state;

    joy_poll_sched #(.POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT), .CENTER(512)) dut (
        .clk(clk), .clr_n(clr_n), .en(en),
        .spi_req(spi_req), .spi_sel(spi_sel), .spi_done(spi_done),
        .spi_x(spi_x), .spi_y(spi_y),
        .joy1_x(joy1_x), .joy1_y(joy1_y), .joy2_x(joy2_x), .joy2_y(joy2_y),
        .upd1(upd1), .upd2(upd2), .err(err), .overrun(overrun),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [9:0]   m_x[2];
    logic [9:0]   m_y[2];
    logic [1:0]   prev_err = 2'b00;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_x[p] = CENTER;
            m_y[p] = CENTER;
        end
    endtask

    task automatic model_sample(input int p, input logic [9:0] x, input logic [9:0] y);
`ifdef JOY_FILTER_EN
        m_x[p] = 10'((int'(m_x[p]) + int'(x)) / 2);
        m_y[p] = 10'((int'(m_y[p]) + int'(y)) / 2);
`else
        m_x[p] = x;
        m_y[p] = y;
`endif
        exp_q.push_back({p[0], m_x[p], m_y[p]});
    endtask

    task automatic model_timeout(input int p);
        m_x[p] = CENTER;
        m_y[p] = CENTER;
        exp_q.push_back({p[0], m_x[p], m_y[p]});
    endtask

    task automatic sb_pop(input int p);
        logic [W-1:0] e;
        logic [W-1:0] o;
        check("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (p == 0) ? {1'b0, joy1_x, joy1_y} : {1'b1, joy2_x, joy2_y};
            check("sb_joy", o, e);
        end
    endtask

    always @(negedge clk) begin
        if (upd1 && upd2) check("upd_overlap", {upd1, upd2}, 0);
        if (upd1 || (err[0] && !prev_err[0])) sb_pop(0);
        if (upd2 || (err[1] && !prev_err[1])) sb_pop(1);
        prev_err = err;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_req(output int rc);
        rc = -1;
        for (int i = 0; i < 64; i++) begin
            if (spi_req === 1'b1) begin
                rc = cyc;
                break;
            end
            @(negedge clk);
        end
        check("req_seen", rc >= 0, 1);
    endtask

    task automatic serve(input int p, input int dly, input logic [9:0] x, input logic [9:0] y,
                         input bit drop_en, output int rc);
        wait_req(rc);
        check("req_sel", spi_sel, p);
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            if (drop_en && k == 0) en = 1'b0;
        end
        spi_done = 1'b1;
        spi_x    = x;
        spi_y    = y;
        model_sample(p, x, y);
        @(negedge clk);
        spi_done = 1'b0;
        spi_x    = $urandom_range(0, 1023);
        spi_y    = $urandom_range(0, 1023);
        check("upd_timing", (p == 0) ? upd1 : upd2, 1);
        if (p == 0) check("req2_after_done", {spi_req, spi_sel}, 2'b11);
        else        check("idle_after_done", {dbg_state, spi_sel}, 0);
    endtask

    task automatic serve_timeout(input int p, output int rc);
        wait_req(rc);
        model_timeout(p);
        repeat (TIMEOUT) @(negedge clk);
        check("err_before_to", err[p], 0);
        @(negedge clk);
        check("err_after_to", err[p], 1);
        check("no_upd_on_to", {upd1, upd2}, 0);
        if (p == 0) check("req2_after_to", {spi_req, spi_sel}, 2'b11);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_joy1"}, {joy1_x, joy1_y}, {CENTER, CENTER});
        check({tag, "_joy2"}, {joy2_x, joy2_y}, {CENTER, CENTER});
        check({tag, "_ctl"}, {spi_req, spi_sel, upd1, upd2, err, overrun, dbg_state}, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r, r1, r2, ra, rc, c0, n;
        clr_n    = 1'b0;
        en       = 1'b0;
        spi_done = 1'b0;
        spi_x    = '0;
        spi_y    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("rst");

        clr_n = 1'b1;
        en    = 1'b1;
        c0    = cyc;

        // normal rounds, reader answers 5 cycles after each request
        serve(0, 5, 10'd100, 10'd900, 0, r1);
        check("first_req_lat", r1 - c0, POLL_DIV);
        serve(1, 5, 10'd700, 10'd300, 0, r);
        serve(0, 5, 10'd321, 10'd654, 0, r2);
        check("round_period", r2 - r1, POLL_DIV);
        serve(1, 5, 10'd1, 10'd1022, 0, r);

        // done on the last WAIT cycle beats the timeout
        serve(0, TIMEOUT, 10'd0, 10'd1023, 0, r);
        serve(1, 1, 10'd1023, 10'd0, 0, r);
        check("err_done_wins", err, 2'b00);

        // player 1 never answers
        serve_timeout(0, r);
        serve(1, 3, 10'd444, 10'd555, 0, r);
        check("err_p1_only", err, 2'b01);

        // round longer than POLL_DIV drops the next tick
        check("overrun_clear", overrun, 0);
        serve(0, 7, 10'd11, 10'd22, 0, ra);
        serve(1, TIMEOUT, 10'd33, 10'd44, 0, r);
        check("overrun_set", overrun, 1);
        serve(0, 2, 10'd55, 10'd66, 0, rc);
        check("overrun_skip_tick", rc - ra, 2 * POLL_DIV);
        serve(1, 2, 10'd77, 10'd88, 0, r);
        check("err_sticky", {err, overrun}, 3'b011);

        // en dropped during WAIT1: round completes, then polling stops
        serve(0, 4, 10'd200, 10'd201, 1, r);
        serve(1, 2, 10'd202, 10'd203, 0, r);
        n = 0;
        repeat (3 * POLL_DIV + 4) begin
            @(negedge clk);
            if (spi_req) n++;
        end
        check("no_req_en_low", n, 0);
        en = 1'b1;
        c0 = cyc;
        serve(0, 3, 10'd300, 10'd301, 0, r);
        check("resume_latency", (r > c0) && (r - c0 <= POLL_DIV), 1);
        serve(1, 3, 10'd302, 10'd303, 0, r);

        // reset in the middle of WAIT1
        wait_req(r);
        repeat (2) @(negedge clk);
        clr_n = 1'b0;
        #1;
        model_reset();
        check_reset_state("midrst");
        check("midrst_sb_empty", exp_q.size(), 0);
        @(negedge clk);
        clr_n = 1'b1;
        c0    = cyc;
        serve(0, 2, 10'd100, 10'd900, 0, r);
        check("req_after_rst", r - c0, POLL_DIV);
        serve(1, 2, 10'd700, 10'd300, 0, r);
        serve(0, 1, 10'd100, 10'd900, 0, r);
        serve(1, 1, 10'd700, 10'd300, 0, r);

        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
